// File: rtl/data_mem_ctrl.sv
// Data memory for the 8-bit datapath: separate read/write ports, a zeroing
// sweep after reset or on request, registered read with valid strobe.
module data_mem_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              collide;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (ptr == '1) state_next = RUN;
            RUN:     if (clr_req) state_next = CLEAR;
            default: state_next = RESET_STATE;
        endcase
    end

    // Pointer wraps to 0 naturally on the edge that clears the last word.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Array has no reset; writes are held off while reset is asserted.
    always_ff @(negedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    assign collide = wr_en && (wr_addr == rd_addr);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (state == RUN && rd_en) begin
            rd_valid <= 1'b1;
            if (WRITE_FIRST != 0 && collide) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the 8-bit microprocessor datapath. It replaces the fixed 16x8 shared-port store with separate read and write ports, usable in the same cycle. It adds a hardware clear sweep, a registered read with a valid strobe, and a selectable read/write collision policy. The block sits between the ALU/accumulator write-back path and the operand fetch path.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- WRITE_FIRST, 0; 0 = read-first (old data on same-address collision), 1 = write-first (new data forwarded)
- CLEAR_ON_RESET, 1; 1 = run a zeroing sweep after reset release, 0 = no sweep

Ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- clr_req  in  1  request a full clear sweep (sampled only in RUN)
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe, rd_data updated this cycle
- busy  out  1  high while sweeping; requests are ignored while high

## Operation
- FSM states: CLEAR, RUN.
- reset low (asynchronous):
  - state = CLEAR if CLEAR_ON_RESET = 1, else RUN
  - sweep pointer = 0
  - rd_data = 0, rd_valid = 0
  - busy = CLEAR_ON_RESET
  - array contents are not reset asynchronously
- CLEAR:
  - each falling edge writes 0 to mem[ptr], then ptr increments
  - after writing ptr = DEPTH-1: ptr wraps to 0, state goes to RUN, busy drops
  - wr_en, rd_en and clr_req are ignored; rd_valid stays 0; rd_data holds its value
- RUN:
  - wr_en = 1: mem[wr_addr] = wr_data
  - rd_en = 1: rd_data is loaded and rd_valid = 1 on the same edge; otherwise rd_valid = 0 and rd_data holds
  - wr_en and rd_en may both be high in the same cycle
  - collision (both enabled, wr_addr == rd_addr): rd_data = wr_data if WRITE_FIRST = 1, else the pre-write contents; the write always lands
  - clr_req = 1: next state CLEAR, busy rises on that edge; any wr_en/rd_en in that same cycle is still performed
  - clr_req while already in CLEAR has no effect (the sweep is not restarted)
- reset asserted mid-sweep or mid-operation: outputs return to reset values immediately; a new sweep starts from address 0 after release.

## Timing
- Write latency 1 edge: data written on edge N is readable by a read issued on edge N+1.
- Read latency 1 edge: rd_en sampled on edge N gives rd_data and rd_valid valid after edge N, held until edge N+1.
- Sweep duration is exactly DEPTH falling edges after reset release: 16 for the defaults.
- busy is registered; it is low from the edge that writes the last sweep location onward.
- Back-to-back reads every cycle keep rd_valid continuously high.

## Test plan
- Reset, then release with defaults -> busy high for exactly 16 falling edges; reading all addresses afterwards returns 0x00 with rd_valid high each cycle.
- Write 0xA5 to addr 3, then read addr 3 on the next cycle -> rd_data = 0xA5 with a 1-cycle rd_valid pulse; rd_data holds 0xA5 while rd_en = 0.
- Addr 7 holds 0x11; write 0x22 to addr 7 and read addr 7 in the same cycle -> rd_data = 0x11 (WRITE_FIRST = 0) or 0x22 (WRITE_FIRST = 1); a later read returns 0x22 in both cases.
- Fill addr 0..15 with 0xFF, pulse clr_req, and drive wr_en (0x55 to addr 2) during the sweep -> busy high for 16 cycles, the write is ignored, and every address reads 0x00.
- Assert reset at sweep step 8, hold 2 cycles, release -> rd_data = 0, rd_valid = 0 immediately; the full 16-cycle sweep reruns; all words read 0x00.
- DATA_W = 16, ADDR_W = 6, CLEAR_ON_RESET = 0 -> busy = 0 out of reset; write 0xBEEF to addr 63, read back 0xBEEF; addr 0 and addr 63 stay independent.
